// File: rtl/serial_add_pkg.sv
// Shared types and constants for the bit-serial adder controller.
package serial_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 32'd8;

  // Replace one bit of a partial result; used to fold the live slice bit into the result.
  function automatic logic [31:0] set_bit(input logic [31:0] vec, input int unsigned idx,
                                          input logic val);
    logic [31:0] tmp;
    tmp      = vec;
    tmp[idx] = val;
    return tmp;
  endfunction

endpackage

// File: rtl/serial_add_ctrl_fa_bit.sv
// Combinational 1-bit full-adder slice shared by every bit of the serial addition.
module fa_bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one full-adder slice, LSB first, WIDTH cycles per add.
// Optional two's-complement overflow output enabled by defining SERIAL_ADD_OVF_EN.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADD_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           state_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [CNT_W-1:0] cnt_r;
  logic             carry_r;
  logic [WIDTH-1:0] part_r;

  logic             slice_a_s;
  logic             slice_b_s;
  logic             slice_s_s;
  logic             slice_cout_s;
  logic [WIDTH-1:0] part_next_s;
  logic             accept_s;

  assign slice_a_s = a_r[cnt_r];
  assign slice_b_s = b_r[cnt_r];

  fa_bit u_fa_bit (
    .a    (slice_a_s),
    .b    (slice_b_s),
    .cin  (carry_r),
    .s    (slice_s_s),
    .cout (slice_cout_s)
  );

  // Partial result with the bit being processed this cycle already merged in.
  always_comb begin
    logic [31:0] wide_s;
    wide_s      = 32'd0;
    wide_s      = set_bit(32'(part_r), 32'(cnt_r), slice_s_s);
    part_next_s = wide_s[WIDTH-1:0];
  end

  // New operands are only taken when the controller is idle or just finished.
  always_comb begin
    accept_s = 1'b0;
    if ((state_r == IDLE) || (state_r == DONE)) begin
      accept_s = start;
    end else begin
      accept_s = 1'b0;
    end
  end

  // Controller state, operand capture, serial datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      a_r     <= '0;
      b_r     <= '0;
      cnt_r   <= '0;
      carry_r <= 1'b0;
      part_r  <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      sum     <= '0;
      cout    <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      ovf     <= 1'b0;
`endif
    end else begin
      case (state_r)
        IDLE, DONE: begin
          done <= 1'b0;
          if (accept_s) begin
            a_r     <= a;
            b_r     <= b;
            carry_r <= cin;
            cnt_r   <= '0;
            part_r  <= '0;
            busy    <= 1'b1;
            state_r <= RUN;
          end else begin
            busy    <= 1'b0;
            state_r <= IDLE;
          end
        end
        RUN: begin
          part_r  <= part_next_s;
          carry_r <= slice_cout_s;
          if (cnt_r == LAST_BIT) begin
            // Final bit: the carry entering it, XOR the carry leaving it, is signed overflow.
            sum     <= part_next_s;
            cout    <= slice_cout_s;
`ifdef SERIAL_ADD_OVF_EN
            ovf     <= carry_r ^ slice_cout_s;
`endif
            busy    <= 1'b0;
            done    <= 1'b1;
            state_r <= DONE;
          end else begin
            cnt_r   <= cnt_r + CNT_W'(1);
            busy    <= 1'b1;
            done    <= 1'b0;
            state_r <= RUN;
          end
        end
        default: begin
          state_r <= IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed self-checking bench for serial_add_ctrl at WIDTH=8 (ovf checked when SERIAL_ADD_OVF_EN is set).
module tb_serial_add_ctrl;

  localparam int W = 8;

  logic         clk;
  logic         reset;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
`ifdef SERIAL_ADD_OVF_EN
  logic         ovf;
`endif

  int checks;
  int errors;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
`ifdef SERIAL_ADD_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse start with the given operands at the next edge (E0).
  task automatic launch(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv);
    a     = av;
    b     = bv;
    cin   = cv;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // From just after E0: expect busy for 8 cycles, sum held, then a single done pulse.
  task automatic finish_add(input string tag, input logic [W-1:0] prev_sum,
                            input logic [W-1:0] exp_sum, input logic exp_cout,
                            input logic exp_ovf);
    int bad_busy;
    int bad_hold;
    bad_busy = 0;
    bad_hold = 0;
    for (int i = 0; i < W; i++) begin
      if (busy !== 1'b1 || done !== 1'b0) bad_busy++;
      if (sum !== prev_sum) bad_hold++;
      tick();
    end
    check_eq({tag, "_busy_run"}, 32'(bad_busy), 32'd0);
    check_eq({tag, "_sum_held"}, 32'(bad_hold), 32'd0);
    check_eq({tag, "_done"}, 32'(done), 32'd1);
    check_eq({tag, "_busy_end"}, 32'(busy), 32'd0);
    check_eq({tag, "_sum"}, 32'(sum), 32'(exp_sum));
    check_eq({tag, "_cout"}, 32'(cout), 32'(exp_cout));
`ifdef SERIAL_ADD_OVF_EN
    check_eq({tag, "_ovf"}, 32'(ovf), 32'(exp_ovf));
`else
    if (exp_ovf === 1'bx) checks = checks;
`endif
  endtask

  initial begin
    int extra_done;
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    start  = 1'b1;
    a      = 8'h00;
    b      = 8'h00;
    cin    = 1'b0;

    // Reset with start held high: must stay idle.
    repeat (3) tick();
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_sum", 32'(sum), 32'd0);
    check_eq("rst_cout", 32'(cout), 32'd0);
    reset = 1'b0;
    start = 1'b0;
    tick();
    check_eq("idle_busy", 32'(busy), 32'd0);

    // Basic add.
    launch(8'h5A, 8'h33, 1'b0);
    finish_add("basic", 8'h00, 8'h8D, 1'b0, 1'b1);
    tick();
    check_eq("basic_done_pulse", 32'(done), 32'd0);

    // Carry through all bits.
    launch(8'hFF, 8'h01, 1'b0);
    finish_add("carry", 8'h8D, 8'h00, 1'b1, 1'b0);
    tick();

    // Carry-in into a signed overflow.
    launch(8'h7F, 8'h00, 1'b1);
    finish_add("ovf", 8'h00, 8'h80, 1'b0, 1'b1);
    tick();

    // Maximum operands with carry-in.
    launch(8'hFF, 8'hFF, 1'b1);
    finish_add("max", 8'h80, 8'hFF, 1'b1, 1'b0);
    tick();

    // Start and operand changes during RUN are ignored.
    launch(8'h5A, 8'h33, 1'b0);
    tick();
    tick();
    a     = 8'h00;
    b     = 8'h00;
    start = 1'b1;
    for (int i = 2; i < W - 1; i++) begin
      check_eq("midrun_busy", 32'(busy), 32'd1);
      tick();
    end
    start = 1'b0;
    tick();
    check_eq("midrun_done", 32'(done), 32'd1);
    check_eq("midrun_sum", 32'(sum), 32'h8D);
    extra_done = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done !== 1'b0 || busy !== 1'b0) extra_done++;
    end
    check_eq("midrun_no_extra", 32'(extra_done), 32'd0);

    // Back-to-back: restart from DONE with no idle cycle.
    launch(8'h10, 8'h20, 1'b0);
    finish_add("b2b_first", 8'h8D, 8'h30, 1'b0, 1'b0);
    launch(8'h01, 8'h02, 1'b0);
    check_eq("b2b_run_next", 32'(busy), 32'd1);
    finish_add("b2b_second", 8'h30, 8'h03, 1'b0, 1'b0);
    tick();

    // Reset while the counter is 4.
    launch(8'hAA, 8'h55, 1'b1);
    repeat (4) tick();
    check_eq("midrst_busy_pre", 32'(busy), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_eq("midrst_busy", 32'(busy), 32'd0);
    check_eq("midrst_sum", 32'(sum), 32'd0);
    check_eq("midrst_cout", 32'(cout), 32'd0);
    extra_done = 0;
    for (int i = 0; i < 12; i++) begin
      if (done !== 1'b0 || busy !== 1'b0) extra_done++;
      tick();
    end
    check_eq("midrst_no_done", 32'(extra_done), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_add_ctrl.md
SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand width in bits (legal range 2..32).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port start  input  1  request to begin one addition; sampled only in IDLE or DONE.
REQ-005 SHALL have port a  input  WIDTH  first operand, captured when start is accepted.
REQ-006 SHALL have port b  input  WIDTH  second operand, captured when start is accepted.
REQ-007 SHALL have port cin  input  1  carry-in, captured when start is accepted.
REQ-008 SHALL have port busy  output  1  high while state is RUN.
REQ-009 SHALL have port done  output  1  one-cycle pulse, high while state is DONE.
REQ-010 SHALL have port sum  output  WIDTH  result of the last completed addition.
REQ-011 SHALL have port cout  output  1  carry-out of the last completed addition.

Function
REQ-012 SHALL implement the FSM states IDLE, RUN and DONE; all outputs SHALL be registered.
REQ-013 SHALL, in IDLE with start=1, capture a, b and cin, clear the bit counter to 0, and enter RUN; with start=0 it SHALL stay in IDLE.
REQ-014 SHALL, in RUN, process exactly one bit per cycle, LSB first, through a single 1-bit full-adder slice.
- Slice inputs: operand bit[counter] and the carry register.
- On each edge: the slice sum bit is written to partial-result bit[counter]; the slice carry-out is written to the carry register.
REQ-015 SHALL increment the counter each RUN cycle and, on the edge processing bit WIDTH-1, do the following: enter DONE, load sum from the partial result, and load cout from the final carry.
REQ-016 SHALL give a fixed latency: start accepted at edge E0; done=1 during the cycle following edge E(WIDTH).
REQ-017 SHALL ignore start while in RUN; captured operands SHALL NOT change mid-operation.
REQ-018 SHALL, in DONE, return to IDLE on the next edge.
- Exception: if start=1 in DONE, SHALL accept the new operands and go directly to RUN (back-to-back operation, no idle cycle).
REQ-019 SHALL hold sum and cout stable from one DONE entry until the next DONE entry; the input operands SHALL NOT affect them in between.
REQ-020 SHALL keep the counter width at clog2(WIDTH) bits; counter SHALL NOT wrap during RUN.

Reset
REQ-021 SHALL, on any edge with reset=1, return to IDLE regardless of state (including mid-RUN) and set busy=0, done=0, sum=0, cout=0; the counter, carry and partial-result registers SHALL also be zeroed.
REQ-022 SHALL give reset priority over start on the same edge.

Configuration
REQ-023 SHALL, with macro SERIAL_ADD_OVF_EN defined, add output port ovf (1 bit, after cout).
- ovf = carry into bit WIDTH-1 XOR final carry-out, i.e. two's-complement overflow.
- ovf SHALL be loaded together with sum and reset to 0.
REQ-024 SHALL, without SERIAL_ADD_OVF_EN, omit the ovf port and its register entirely; all other behaviour SHALL be identical.

Structure
REQ-025 SHALL place the state encoding typedef (IDLE=0, RUN=1, DONE=2) and the default WIDTH constant in shared package serial_add_pkg.
REQ-026 SHALL implement the 1-bit full adder as sub-module fa_bit (inputs a, b, cin; outputs s, cout; combinational), instantiated exactly once.

Verification (WIDTH=8)
REQ-027 SHALL cover reset: after reset, sum=0x00, cout=0, busy=0, done=0; with start held high during reset, state SHALL remain IDLE.
REQ-028 SHALL cover a basic add: a=0x5A, b=0x33, cin=0, start pulsed at E0 -> busy=1 for 8 cycles; done=1 after E8 only; sum=0x8D, cout=0.
REQ-029 SHALL cover carry propagation and overflow:
- a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1, ovf=0 (macro on).
- a=0x7F, b=0x00, cin=1 -> sum=0x80, cout=0, ovf=1.
REQ-030 SHALL cover start during RUN: operands changed to 0x00 and start held high mid-RUN -> result unchanged from the captured operands; no extra done pulse.
REQ-031 SHALL cover back-to-back operation: start=1 in DONE with a=0x01, b=0x02 -> RUN entered next edge, previous sum held until the next done, then sum=0x03.
REQ-032 SHALL cover reset mid-operation: reset asserted while the counter is 4 -> next cycle IDLE, sum=0, busy=0, and no done pulse.
